// File: rtl/core_seq_pkg.sv
// Shared definitions for the core instruction sequencer.
//   - seq_state_t : sequencer FSM states
//   - I_*         : bit positions inside the 34-bit core instruction word
//   - INST_IDLE   : instruction value with every SRAM deselected and all strobes low
//   - calc_geom() : derives len_nij (n), onij (o) and output width (ow) from an input width
package core_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_L0,
    S_W_LOAD,
    S_GAP,
    S_X_L0,
    S_EXEC,
    S_DWAIT,
    S_DRAIN,
    S_ACC,
    S_DONE
  } seq_state_t;

  localparam int INST_W  = 34;
  localparam int INST_AW = 11;

  localparam int I_ACC      = 33;
  localparam int I_CEN_PMEM = 32;
  localparam int I_WEN_PMEM = 31;
  localparam int I_A_PMEM   = 20;
  localparam int I_CEN_XMEM = 19;
  localparam int I_WEN_XMEM = 18;
  localparam int I_A_XMEM   = 7;
  localparam int I_OFIFO_RD = 6;
  localparam int I_IFIFO_WR = 5;
  localparam int I_IFIFO_RD = 4;
  localparam int I_L0_RD    = 3;
  localparam int I_L0_WR    = 2;
  localparam int I_EXECUTE  = 1;
  localparam int I_LOAD     = 0;

  // Chip enables and write enables are active low, so "nothing happening" has them high.
  localparam logic [INST_W-1:0] INST_IDLE = (34'd1 << I_CEN_PMEM) | (34'd1 << I_WEN_PMEM) |
                                            (34'd1 << I_CEN_XMEM) | (34'd1 << I_WEN_XMEM);

  typedef struct packed {
    logic [15:0] n;
    logic [15:0] o;
    logic [15:0] ow;
  } geom_t;

  function automatic geom_t calc_geom(input int w, input int ksz);
    geom_t g;
    g.n  = 16'(w * w);
    g.ow = 16'(w - ksz + 1);
    g.o  = 16'((w - ksz + 1) * (w - ksz + 1));
    return g;
  endfunction

endpackage

// File: rtl/core_acc_addr_gen.sv
// PMEM read address generator for the accumulation phase.
// Walks output pixels (column counter, wrapping rows) and kernel offsets
// (kernel column counter, wrapping kernel rows) using only additions.
//   clk, reset   : clock, async active-low reset
//   init         : restart at output 0, kernel offset 0
//   step         : advance to the next kernel offset of the current output
//   next_out     : advance to kernel offset 0 of the next output
//   n_len        : psum plane size per kij (len_nij)
//   w_len        : input width
//   ow_len       : output width
//   addr         : registered PMEM address for the current (output, k)
module core_acc_addr_gen
  import core_seq_pkg::*;
#(
  parameter int AW     = 11,
  parameter int KSZ    = 3,
  parameter int P_BASE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          step,
  input  logic          next_out,
  input  logic [15:0]   n_len,
  input  logic [15:0]   w_len,
  input  logic [15:0]   ow_len,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] P_BASE_A = AW'(P_BASE);
  localparam logic [AW-1:0] KSZ_A    = AW'(KSZ);
  localparam logic [AW-1:0] KSZ_M1_A = AW'(KSZ - 1);
  localparam logic [15:0]   KCOL_END = 16'(KSZ - 1);

  logic [AW-1:0] out_base;
  logic [15:0]   col;
  logic [15:0]   kcol;

  // out_base is the address of kernel offset 0 for the current output
  // (P_BASE + r*W + c). Moving along a row adds 1; wrapping to the next
  // output row skips the KSZ-1 pixels the kernel cannot start on, i.e. adds KSZ.
  // Within a kernel, the next column adds one psum plane plus one pixel; the
  // next kernel row adds one plane plus one image row minus the columns walked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_base <= P_BASE_A;
      addr     <= P_BASE_A;
      col      <= '0;
      kcol     <= '0;
    end else if (init) begin
      out_base <= P_BASE_A;
      addr     <= P_BASE_A;
      col      <= '0;
      kcol     <= '0;
    end else if (next_out) begin
      kcol <= '0;
      if (col == ow_len - 16'd1) begin
        col      <= '0;
        out_base <= out_base + KSZ_A;
        addr     <= out_base + KSZ_A;
      end else begin
        col      <= col + 16'd1;
        out_base <= out_base + AW'(1);
        addr     <= out_base + AW'(1);
      end
    end else if (step) begin
      if (kcol == KCOL_END) begin
        kcol <= '0;
        addr <= addr + AW'(n_len) + AW'(w_len) - KSZ_M1_A;
      end else begin
        kcol <= kcol + 16'd1;
        addr <= addr + AW'(n_len) + AW'(1);
      end
    end
  end

endmodule

// File: rtl/core_inst_seq.sv
// Hardware instruction sequencer for the systolic core. For every kernel
// offset kij it fetches weights into L0, loads them, fetches activations,
// executes, waits for the OFIFO and drains it to PMEM; then it accumulates
// the KSZ*KSZ partial sums of every output pixel through the SFP.
//   clk, reset   : clock, async active-low reset
//   start        : begin a pass (only honoured in IDLE)
//   mode         : 0 = 4b activations, 1 = 2b activations (latched at start)
//   ofifo_valid  : core output FIFO has data
//   inst         : registered 34-bit core instruction
//   sfp_clr      : one-cycle SFP accumulator clear
//   out_valid    : SFP output for out_idx is ready
//   out_idx      : output featuremap index
//   busy         : pass in progress
//   done         : one-cycle end-of-pass pulse
//   err          : sticky OFIFO drain timeout, cleared by start
module core_inst_seq
  import core_seq_pkg::*;
#(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int KSZ      = 3,
  parameter int IN_W0    = 8,
  parameter int IN_W1    = 4,
  parameter int COL1     = 16,
  parameter int AW       = 11,
  parameter int W_BASE   = 1024,
  parameter int P_BASE   = 0,
  parameter int GAP_CYC  = 10,
  parameter int DRAIN_TO = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic          ofifo_valid,
  output logic [33:0]   inst,
  output logic          sfp_clr,
  output logic          out_valid,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int K2 = KSZ * KSZ;

  localparam geom_t G0 = calc_geom(IN_W0, KSZ);
  localparam geom_t G1 = calc_geom(IN_W1, KSZ);

  localparam logic [AW-1:0] W_BASE_A = AW'(W_BASE);
  localparam logic [AW-1:0] P_BASE_A = AW'(P_BASE);
  localparam logic [15:0]   GAP_LAST = 16'(GAP_CYC - 1);
  localparam logic [15:0]   TO_LAST  = 16'(DRAIN_TO - 1);
  localparam logic [15:0]   K2_V     = 16'(K2);
  localparam logic [15:0]   K2_LAST  = 16'(K2 - 1);
  localparam logic [15:0]   ACC_LAST = 16'(K2 + 2);

  localparam bit PARAMS_OK = (ROW > 0) && (COL > 0) && (COL1 > 0) && (GAP_CYC > 0) &&
                             (P_BASE + K2 * IN_W0 * IN_W0 <= (1 << AW)) &&
                             (P_BASE + K2 * IN_W1 * IN_W1 <= (1 << AW));

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("core_inst_seq: geometry parameters do not fit the address space");
    end
  endgenerate

  seq_state_t    state;
  logic [15:0]   cnt;
  logic [15:0]   kij;
  logic [15:0]   o_cnt;
  logic [15:0]   n_len, o_len, ow_len, c_len, w_len;
  logic [AW-1:0] x_addr;
  logic [AW-1:0] p_addr;
  logic [AW-1:0] acc_addr;

  logic gen_init, gen_step, gen_next;

  logic [INST_W-1:0] inst_d;
  logic              sfp_clr_d, out_valid_d, busy_d, done_d;
  logic [AW-1:0]     out_idx_d;

  // Weight reads (W_BASE + kij*C + n) and psum writes (P_BASE + kij*N + n)
  // are contiguous across kij, so plain running pointers replace the multiplies.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      kij    <= '0;
      o_cnt  <= '0;
      n_len  <= '0;
      o_len  <= '0;
      ow_len <= '0;
      c_len  <= '0;
      w_len  <= '0;
      x_addr <= '0;
      p_addr <= '0;
      err    <= 1'b0;
    end else begin
      cnt <= cnt + 16'd1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            if (mode) begin
              n_len  <= G1.n;
              o_len  <= G1.o;
              ow_len <= G1.ow;
              c_len  <= 16'(COL1);
              w_len  <= 16'(IN_W1);
            end else begin
              n_len  <= G0.n;
              o_len  <= G0.o;
              ow_len <= G0.ow;
              c_len  <= 16'(COL);
              w_len  <= 16'(IN_W0);
            end
            kij    <= '0;
            o_cnt  <= '0;
            x_addr <= W_BASE_A;
            p_addr <= P_BASE_A;
            err    <= 1'b0;
            state  <= S_W_L0;
          end
        end
        S_W_L0: begin
          if (cnt < c_len) x_addr <= x_addr + AW'(1);
          if (cnt == c_len) begin
            cnt   <= '0;
            state <= S_W_LOAD;
          end
        end
        S_W_LOAD: begin
          if (cnt == (c_len << 1) - 16'd1) begin
            cnt   <= '0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_X_L0;
          end
        end
        S_X_L0: begin
          if (cnt == n_len) begin
            cnt   <= '0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == n_len - 16'd1) begin
            cnt   <= '0;
            state <= S_DWAIT;
          end
        end
        S_DWAIT: begin
          if (ofifo_valid) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else if (cnt == TO_LAST) begin
            cnt   <= '0;
            err   <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DRAIN: begin
          if (cnt != 16'd0) p_addr <= p_addr + AW'(1);
          if (cnt == n_len) begin
            cnt <= '0;
            if (kij == K2_LAST) begin
              o_cnt <= '0;
              state <= S_ACC;
            end else begin
              kij   <= kij + 16'd1;
              state <= S_W_L0;
            end
          end
        end
        S_ACC: begin
          if (cnt == ACC_LAST) begin
            cnt <= '0;
            if (o_cnt == o_len - 16'd1) begin
              state <= S_DONE;
            end else begin
              o_cnt <= o_cnt + 16'd1;
            end
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The generator must present the address for k = cnt-1 during ACC cycle cnt,
  // so it is stepped at the end of cycles 1..K2-1 and moved to the next output
  // at the end of the last cycle of each output.
  always_comb begin
    gen_init = (state == S_DRAIN) && (cnt == n_len) && (kij == K2_LAST);
    gen_step = (state == S_ACC) && (cnt >= 16'd1) && (cnt <= K2_LAST);
    gen_next = (state == S_ACC) && (cnt == ACC_LAST) && (o_cnt != o_len - 16'd1);
  end

  core_acc_addr_gen #(
    .AW     (AW),
    .KSZ    (KSZ),
    .P_BASE (P_BASE)
  ) u_acc_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .init     (gen_init),
    .step     (gen_step),
    .next_out (gen_next),
    .n_len    (n_len),
    .w_len    (w_len),
    .ow_len   (ow_len),
    .addr     (acc_addr)
  );

  // Instruction decode from the current state/counter; registered below, so
  // every strobe appears one cycle after the counter value that produced it.
  // SRAM reads have one cycle of latency, hence l0_wr trails the reads by one.
  always_comb begin
    inst_d      = INST_IDLE;
    sfp_clr_d   = 1'b0;
    out_valid_d = 1'b0;
    out_idx_d   = out_idx;
    done_d      = 1'b0;
    busy_d      = (state != S_IDLE) && (state != S_DONE);
    case (state)
      S_W_L0: begin
        if (cnt < c_len) begin
          inst_d[I_CEN_XMEM]             = 1'b0;
          inst_d[I_A_XMEM +: INST_AW]    = INST_AW'(x_addr);
        end
        if (cnt != 16'd0) inst_d[I_L0_WR] = 1'b1;
      end
      S_W_LOAD: begin
        inst_d[I_L0_RD] = 1'b1;
        inst_d[I_LOAD]  = 1'b1;
      end
      S_X_L0: begin
        if (cnt < n_len) begin
          inst_d[I_CEN_XMEM]             = 1'b0;
          inst_d[I_A_XMEM +: INST_AW]    = INST_AW'(cnt);
        end
        if (cnt != 16'd0) inst_d[I_L0_WR] = 1'b1;
      end
      S_EXEC: begin
        inst_d[I_L0_RD]   = 1'b1;
        inst_d[I_EXECUTE] = 1'b1;
      end
      S_DRAIN: begin
        if (cnt < n_len) inst_d[I_OFIFO_RD] = 1'b1;
        if (cnt != 16'd0) begin
          inst_d[I_CEN_PMEM]          = 1'b0;
          inst_d[I_WEN_PMEM]          = 1'b0;
          inst_d[I_A_PMEM +: INST_AW] = INST_AW'(p_addr);
        end
      end
      S_ACC: begin
        if (cnt == 16'd0) sfp_clr_d = 1'b1;
        if ((cnt >= 16'd1) && (cnt <= K2_V)) begin
          inst_d[I_CEN_PMEM]          = 1'b0;
          inst_d[I_A_PMEM +: INST_AW] = INST_AW'(acc_addr);
        end
        if ((cnt >= 16'd2) && (cnt <= K2_V + 16'd1)) inst_d[I_ACC] = 1'b1;
        if (cnt == ACC_LAST) begin
          out_valid_d = 1'b1;
          out_idx_d   = AW'(o_cnt);
        end
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers; reset forces every SRAM deselected and all pulses low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst      <= INST_IDLE;
      sfp_clr   <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      inst      <= inst_d;
      sfp_clr   <= sfp_clr_d;
      out_valid <= out_valid_d;
      out_idx   <= out_idx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// Self-checking bench for core_inst_seq. Expected XMEM reads, PMEM writes,
// PMEM reads and output indices are queued when a pass is started and popped
// as the DUT issues them; per-pass statistics are checked when done pulses.
module tb_core_inst_seq;

  localparam int ROW      = 8;
  localparam int COL      = 8;
  localparam int KSZ      = 3;
  localparam int IN_W0    = 8;
  localparam int IN_W1    = 4;
  localparam int COL1     = 16;
  localparam int AW       = 11;
  localparam int W_BASE   = 1024;
  localparam int P_BASE   = 0;
  localparam int GAP_CYC  = 10;
  localparam int DRAIN_TO = 1023;
  localparam int K2       = KSZ * KSZ;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          ofifo_valid = 1'b1;
  logic [33:0]   inst;
  logic          sfp_clr, out_valid, busy, done, err;
  logic [AW-1:0] out_idx;

  core_inst_seq #(
    .ROW(ROW), .COL(COL), .KSZ(KSZ), .IN_W0(IN_W0), .IN_W1(IN_W1), .COL1(COL1),
    .AW(AW), .W_BASE(W_BASE), .P_BASE(P_BASE), .GAP_CYC(GAP_CYC), .DRAIN_TO(DRAIN_TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .sfp_clr     (sfp_clr),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int xq[$], pwq[$], prq[$], oq[$], exec_lens[$];
  int cyc = 0, busy_rise = -1, done_cyc = -1, done_cnt = 0, out_cnt = 0;
  int acc_cnt = 0, sfp_cnt = 0, first_xrd = -1, first_l0wr = -1;
  int exec_run = 0, last_exec = -1, err_rise = -1;
  int exp_cycles = 0, exp_n = 0, exp_o = 0;
  int mon_exp;
  logic busy_q = 1'b0, err_q = 1'b0;
  logic [33:0] rst_inst;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clearStats();
    xq.delete(); pwq.delete(); prq.delete(); oq.delete(); exec_lens.delete();
    busy_rise = -1; done_cyc = -1; done_cnt = 0; out_cnt = 0; acc_cnt = 0; sfp_cnt = 0;
    first_xrd = -1; first_l0wr = -1; exec_run = 0; last_exec = -1; err_rise = -1;
  endtask

  // Expected transactions of one pass, from the closed-form address equations.
  task automatic pushRun(input logic m, input bit full);
    int c, w, n, ow, o, r, cc;
    c  = m ? COL1 : COL;
    w  = m ? IN_W1 : IN_W0;
    n  = w * w;
    ow = w - KSZ + 1;
    o  = ow * ow;
    exp_n = n;
    exp_o = o;
    exp_cycles = K2 * ((c + 1) + 2 * c + GAP_CYC + (n + 1) + n + 1 + (n + 1)) + o * (K2 + 3);
    for (int kij = 0; kij < (full ? K2 : 1); kij++) begin
      for (int i = 0; i < c; i++) xq.push_back(W_BASE + kij * c + i);
      for (int i = 0; i < n; i++) xq.push_back(i);
      if (full) for (int i = 0; i < n; i++) pwq.push_back(P_BASE + kij * n + i);
    end
    if (full) begin
      for (int oo = 0; oo < o; oo++) begin
        r  = oo / ow;
        cc = oo % ow;
        for (int k = 0; k < K2; k++)
          prq.push_back(P_BASE + k * n + (r + k / KSZ) * w + cc + k % KSZ);
        oq.push_back(oo);
      end
    end
  endtask

  task automatic waitDone(input int limit);
    int k;
    k = 0;
    while (done_cnt == 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == 0) checkOutput("done_timeout", done_cnt, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic checkRun(input bit full);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("busy_after", busy, 0);
    checkOutput("xmem_left", xq.size(), 0);
    checkOutput("pmem_wr_left", pwq.size(), 0);
    checkOutput("pmem_rd_left", prq.size(), 0);
    checkOutput("out_left", oq.size(), 0);
    checkOutput("l0wr_lag", first_l0wr - first_xrd, 1);
    if (full) begin
      checkOutput("run_cycles", done_cyc - busy_rise, exp_cycles);
      checkOutput("out_pulses", out_cnt, exp_o);
      checkOutput("acc_cycles", acc_cnt, exp_o * K2);
      checkOutput("sfp_clr_pulses", sfp_cnt, exp_o);
      checkOutput("exec_runs", exec_lens.size(), K2);
      checkOutput("err_clear", err, 0);
    end else begin
      checkOutput("err_set", err, 1);
      checkOutput("dwait_len", err_rise - last_exec, DRAIN_TO);
      checkOutput("exec_runs", exec_lens.size(), 1);
      checkOutput("out_pulses", out_cnt, 0);
    end
    foreach (exec_lens[i]) checkOutput("exec_len", exec_lens[i], exp_n);
  endtask

  // Monitor: sample registered outputs on the falling edge and score transactions.
  always @(negedge clk) begin
    cyc++;
    if (busy && !busy_q) busy_rise = cyc;
    busy_q = busy;
    if (err && !err_q) err_rise = cyc;
    err_q = err;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_valid) begin
      out_cnt++;
      if (oq.size() > 0) mon_exp = oq.pop_front(); else mon_exp = -1;
      checkOutput("out_idx", out_idx, mon_exp);
    end
    if (!inst[19]) begin
      if (first_xrd < 0) first_xrd = cyc;
      if (xq.size() > 0) mon_exp = xq.pop_front(); else mon_exp = -1;
      checkOutput("xmem_rd_addr", inst[17:7], mon_exp);
      checkOutput("xmem_wen", inst[18], 1);
    end
    if (inst[2] && first_l0wr < 0) first_l0wr = cyc;
    if (!inst[32]) begin
      if (!inst[31]) begin
        if (pwq.size() > 0) mon_exp = pwq.pop_front(); else mon_exp = -1;
        checkOutput("pmem_wr_addr", inst[30:20], mon_exp);
      end else begin
        if (prq.size() > 0) mon_exp = prq.pop_front(); else mon_exp = -1;
        checkOutput("pmem_rd_addr", inst[30:20], mon_exp);
      end
    end
    if (inst[33]) acc_cnt++;
    if (sfp_clr) sfp_cnt++;
    if (inst[1]) begin
      exec_run++;
      last_exec = cyc;
    end else if (exec_run > 0) begin
      exec_lens.push_back(exec_run);
      exec_run = 0;
    end
    checkOutput("ififo_idle", inst[5:4], 0);
  end

  initial begin
    int k;
    rst_inst = '0;
    rst_inst[32] = 1'b1;
    rst_inst[31] = 1'b1;
    rst_inst[19] = 1'b1;
    rst_inst[18] = 1'b1;

    // Asynchronous reset values
    #2 reset = 1'b0;
    #2;
    checkOutput("rst_inst", inst, rst_inst);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_sfp_clr", sfp_clr, 0);
    checkOutput("rst_out_idx", out_idx, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0 undisturbed pass
    $display("[TB] mode 0 pass");
    clearStats();
    pushRun(1'b0, 1'b1);
    applyStimulus(1'b0);
    waitDone(4000);
    checkRun(1'b1);

    // Mode 0 pass with a stray start (mode 1) during the first drain
    $display("[TB] mode 0 pass with start during drain");
    clearStats();
    pushRun(1'b0, 1'b1);
    applyStimulus(1'b0);
    k = 0;
    while (!inst[6] && k < 1000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("drain_reached", inst[6], 1);
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b0;
    waitDone(4000);
    checkRun(1'b1);

    // Mode 1 pass; mode input changes after start and must be ignored
    $display("[TB] mode 1 pass");
    clearStats();
    pushRun(1'b1, 1'b1);
    applyStimulus(1'b1);
    mode = 1'b0;
    waitDone(2000);
    checkRun(1'b1);

    // Drain timeout: OFIFO never becomes valid
    $display("[TB] drain timeout");
    ofifo_valid = 1'b0;
    clearStats();
    pushRun(1'b0, 1'b0);
    applyStimulus(1'b0);
    waitDone(3000);
    checkRun(1'b0);
    ofifo_valid = 1'b1;

    // Restart clears err; then abort with reset in the middle of EXEC
    $display("[TB] reset during exec");
    clearStats();
    pushRun(1'b0, 1'b1);
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    checkOutput("err_cleared_by_start", err, 0);
    k = 0;
    while (!inst[1] && k < 1000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("exec_reached", inst[1], 1);
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_inst", inst, rst_inst);
    checkOutput("abort_busy", busy, 0);
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", done_cnt, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Clean pass after the abort
    $display("[TB] mode 1 pass after abort");
    clearStats();
    pushRun(1'b1, 1'b1);
    applyStimulus(1'b1);
    waitDone(2000);
    checkRun(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
- Hardware instruction sequencer that replaces bench-driven stimulus for the systolic core.
- Generates the 34-bit core instruction word for a full convolution pass over all kij kernel offsets:
  - weight fetch to L0
  - kernel load
  - activation fetch
  - execute
  - OFIFO drain to PMEM
  - per-output accumulation
- Parametrised in array geometry, kernel size and image size; mode input selects 4b/4b or 2b/4b geometry at run time.
- Sits between the host/top-level start logic and core.inst; observes core.ofifo_valid.

Parameters:
- ROW, 8, PE rows
- COL, 8, PE columns (mode 0 weight rows)
- KSZ, 3, kernel edge; kij count = KSZ*KSZ
- IN_W0, 8, mode 0 input width; len_nij = IN_W0², onij = (IN_W0-KSZ+1)²
- IN_W1, 4, mode 1 input width
- COL1, 16, mode 1 weight rows (2-bit packing)
- AW, 11, SRAM address width
- W_BASE, 1024, XMEM weight region base
- P_BASE, 0, PMEM psum base
- GAP_CYC, 10, idle cycles after kernel load
- DRAIN_TO, 1023, max cycles waiting for ofifo_valid

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; begin pass (sampled in IDLE only)
- mode  in  1  0: 4b act, 1: 2b act; latched at start
- ofifo_valid  in  1  from core
- inst  out  34  core instruction, registered; bit map:
  - [33] acc
  - [32] CEN_pmem
  - [31] WEN_pmem
  - [30:20] A_pmem
  - [19] CEN_xmem
  - [18] WEN_xmem
  - [17:7] A_xmem
  - [6] ofifo_rd
  - [5] ififo_wr
  - [4] ififo_rd
  - [3] l0_rd
  - [2] l0_wr
  - [1] execute
  - [0] load
- sfp_clr  out  1  one-cycle clear of SFP accumulator
- out_valid  out  1  pulse: sfp_out holds output out_idx
- out_idx  out  AW  output featuremap index
- busy  out  1  high outside IDLE/DONE
- done  out  1  one-cycle pulse at pass end
- err  out  1  sticky drain timeout; cleared by start

Behaviour:
- Reset (reset=0, async) drives all outputs to their reset values:
  - inst: CEN/WEN bits =1, all other bits 0
  - sfp_clr, out_valid, busy, done, err = 0; out_idx = 0
- Reset mid-operation aborts the pass immediately to IDLE with no completion pulse.
- All outputs are registered. inst changes one cycle after the state/counter change.
- Geometry registers latched at start:
  - N = len_nij
  - O = onij
  - C = COL or COL1
  - W = IN_W0 or IN_W1
  - OW = W-KSZ+1
- States and durations per kij (kij = 0..KSZ²-1):
  - W_L0, C+1 cycles:
    - cycle n<C: CEN_xmem=0, WEN_xmem=1, A_xmem = W_BASE + kij*C + n
    - l0_wr=1 on cycles 1..C (SRAM read latency of 1)
  - W_LOAD, 2C cycles: l0_rd=1, load=1.
  - GAP, GAP_CYC cycles: all strobes idle.
  - X_L0, N+1 cycles: read A_xmem = n for n<N; l0_wr on cycles 1..N.
  - EXEC, N cycles: l0_rd=1, execute=1.
  - DWAIT: hold until ofifo_valid=1.
    - If DRAIN_TO cycles elapse first: set err, go to DONE.
  - DRAIN, N+1 cycles:
    - ofifo_rd=1 on cycles 0..N-1
    - CEN_pmem=0, WEN_pmem=0, A_pmem = P_BASE + kij*N + (n-1) on cycles 1..N
  - Last kij goes to ACC; otherwise kij+1 goes to W_L0.
- ACC, per output o = 0..O-1, with r = o/OW, c = o%OW; KSZ²+3 cycles:
  - cycle 0: sfp_clr=1.
  - cycles 1..KSZ²: CEN_pmem=0, WEN_pmem=1, A_pmem = P_BASE + k*N + (r+k/KSZ)*W + c + k%KSZ, with k = cycle-1.
  - acc=1 on cycles 2..KSZ²+1.
  - cycle KSZ²+2: out_valid=1, out_idx=o.
- DONE: done=1 for one cycle, then IDLE.
- Simultaneous or duplicate start while busy is ignored.
- Address arithmetic is AW bits; wrap is not checked. Parameters must keep P_BASE + KSZ²*N ≤ 2^AW.
- ififo_wr and ififo_rd are always 0.

Decomposition:
- Shared package core_seq_pkg holds:
  - state enum
  - inst bit-position constants
  - geometry helper function (N, O, OW from W)
- One sub-module core_acc_addr_gen: registered generator computing (r, c, k) and A_pmem with incremental counters (no dividers).

Test Plan:
- Mode 0, default params, start: first W_L0 A_xmem=1024, l0_wr rises 1 cycle after first read. EXEC lasts exactly 64 cycles. DRAIN writes PMEM 0..63 for kij=0 and 512..575 for kij=8.
- Mode 0 ACC, output 0: A_pmem sequence 0, 65, 130, 200, 265, 330, 400, 465, 530. Output 35 (r=5, c=5) first address = 45. 36 out_valid pulses, then a single done.
- Mode 1: C=16 weight rows at 1024 + kij*16. N=16, O=4. Output 3 (r=1, c=1) addresses start at 5. Exactly 4 out_valid pulses.
- Hold ofifo_valid=0 after EXEC: err=1 after 1023 cycles, done pulses, no PMEM writes. The next start clears err.
- Assert reset low mid-EXEC: inst returns to its reset value asynchronously, busy=0, no done pulse. A subsequent start runs cleanly from kij=0.
- Pulse start during DRAIN: no effect, and the sequence and cycle count are identical to the undisturbed run.
